alu_operand_sel: RTL and testbench
==================================

Name: alu_operand_sel

Overview:
- Parametrised, buffered successor to the two-stage ALU operand mux for the GF(2^m) ECC datapath.
- Selects the X and Z ALU operands from NSRC register sources by index, with optional swap and constant-force.
- Captures the selected operands into a 2-entry FIFO with valid/ready handshakes on both sides.
- Sits between the point/register file and the field ALU, so the controller can issue operand requests ahead of ALU consumption.

Parameters:
WIDTH, 163, field element width in bits
NSRC, 6, number of operand sources on src_bus (2..16)
SELW, 4, width of select codes; must satisfy 2^SELW >= NSRC
TAGW, 4, width of sideband tag carried with each request

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
src_bus  input  NSRC*WIDTH  sources packed; source i = src_bus[i*WIDTH +: WIDTH]
req_valid  input  1  operand request present
req_ready  output  1  FIFO can accept a request this cycle
req_sel_x  input  SELW  source index for X operand
req_sel_z  input  SELW  source index for Z operand
req_swap  input  1  1: exchange the X and Z operands after selection
req_cz  input  2  constant-force for Z operand; 00 = selected source, 01 = all-zero, 10 = one (bit0=1, rest 0), 11 = selected source
req_tag  input  TAGW  sideband tag, returned unchanged with the operands
out_valid  output  1  head FIFO entry valid
out_ready  input  1  ALU consumes the head entry
alu_x  output  WIDTH  head entry X operand
alu_z  output  WIDTH  head entry Z operand
out_tag  output  TAGW  head entry tag
occupancy  output  2  number of FIFO entries held (0..2)
sel_err  output  1  sticky flag: an out-of-range select was accepted
err_clr  input  1  synchronous clear of sel_err

Behaviour:
- Reset state (asynchronous, while rst=1):
  - occupancy=0, out_valid=0, sel_err=0.
  - alu_x, alu_z, out_tag and all FIFO storage are 0.
  - req_ready is forced to 0 while rst=1.
- Request side:
  - req_ready = !rst && (occupancy < 2). It is derived from registered state only; there is no combinational path from out_ready.
  - Push happens when req_valid && req_ready at a rising edge.
- Operand computation, from src_bus as sampled on the push edge:
  - x_sel = src[req_sel_x].
  - z_sel = src[req_sel_z], then the req_cz override is applied.
  - If req_swap=1: stored X = z result, stored Z = x_sel. Otherwise stored X = x_sel, stored Z = z result.
  - The constant-force always applies before the swap.
- Out-of-range select (index >= NSRC):
  - The corresponding operand is all-zero.
  - sel_err is set on the push edge.
  - sel_err is cleared only by err_clr=1 or rst. If err_clr and a new error occur on the same edge, set wins.
- Output side:
  - The head entry drives alu_x, alu_z and out_tag. out_valid = (occupancy != 0).
  - Pop happens when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, alu_x, alu_z and out_tag hold stable.
  - When occupancy=0, the outputs hold the last popped values; nothing reads them while out_valid=0.
- Latency:
  - A request pushed at edge N gives out_valid=1 after edge N if the FIFO was empty. There is no same-cycle bypass.
  - Entries leave in strict FIFO order.
- Occupancy update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. This is legal only at occupancy 1; at occupancy 2 req_ready=0, so no push occurs.
  - When full, a pop frees a slot and req_ready rises on the following cycle.
- Storage wrap-around:
  - Two entries, with 1-bit write and read pointers toggling on push and pop respectively.
  - occupancy is the authoritative full/empty indicator.
- Reset mid-operation:
  - All entries are discarded immediately and asynchronously.
  - An in-flight push on the edge where rst rises is lost.
- src_bus changes after the push edge do not affect stored entries.

Test Plan:
1. Basic select: src0=0x1, src3=0xABC, push sel_x=3, sel_z=0, swap=0, cz=00, tag=5, out_ready=1 -> one cycle later out_valid=1, alu_x=0xABC, alu_z=0x1, out_tag=5; popped, occupancy returns to 0.
2. Swap and constant: sel_x=2 (src2=0x77), cz=10, swap=1 -> alu_x=0x1, alu_z=0x77. Then cz=01, swap=0 -> alu_z=0, alu_x=0x77.
3. Backpressure/full: out_ready=0, push tags 1, 2 -> occupancy=2, req_ready=0. A third request (tag 3) is held. Outputs stay stable with tag 1. Raise out_ready for 1 cycle -> tag 2 at head, req_ready=1 the next cycle, tag 3 is accepted; order on the output is 1, 2, 3.
4. Simultaneous push/pop: occupancy=1, req_valid=1, out_ready=1 for 4 cycles -> occupancy stays 1 and tags emerge in order, one per cycle.
5. Error flag: NSRC=6, push sel_z=7 -> alu_z=0 and sel_err=1, held until err_clr. An err_clr pulse on the same edge as another bad push leaves sel_err=1.
6. Reset mid-stream: occupancy=2, assert rst asynchronously mid-cycle -> out_valid, occupancy and outputs go to 0 immediately and req_ready=0. After release, req_ready=1 and no stale entries appear.

Source files
------------

// File: rtl/alu_operand_sel.sv
// alu_operand_sel: selects X/Z field-ALU operands from NSRC sources (swap, Z constant-force) into a 2-entry FIFO.
// Latency: one cycle. A push at edge N is visible on alu_x/alu_z/out_tag after edge N. There is no bypass.
// Backpressure: req_ready depends only on registered occupancy, so it has no path from out_ready. The head holds while out_ready=0.
module alu_operand_sel #(
  parameter int WIDTH = 163,
  parameter int NSRC  = 6,
  parameter int SELW  = 4,
  parameter int TAGW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SELW-1:0]       req_sel_x,
  input  logic [SELW-1:0]       req_sel_z,
  input  logic                  req_swap,
  input  logic [1:0]            req_cz,
  input  logic [TAGW-1:0]       req_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      alu_x,
  output logic [WIDTH-1:0]      alu_z,
  output logic [TAGW-1:0]       out_tag,
  output logic [1:0]            occupancy,
  output logic                  sel_err,
  input  logic                  err_clr
);

  // FIFO storage. Occupancy, not the pointers, decides full/empty.
  logic [WIDTH-1:0] x_mem_q   [2];
  logic [WIDTH-1:0] z_mem_q   [2];
  logic [TAGW-1:0]  tag_mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] x_sel, z_sel, z_res, x_store, z_store;
  logic             x_oor, z_oor;
  logic             push, pop;
  logic             head_idx;

  // Source mux. An index with no matching source leaves the operand at zero.
  always_comb begin
    x_sel = '0;
    z_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(req_sel_x) == i) x_sel = src_bus[i*WIDTH +: WIDTH];
      if (int'(req_sel_z) == i) z_sel = src_bus[i*WIDTH +: WIDTH];
    end
    x_oor = (int'(req_sel_x) >= NSRC);
    z_oor = (int'(req_sel_z) >= NSRC);
  end

  // Apply the Z constant-force first, then the optional swap.
  always_comb begin
    case (req_cz)
      2'b01:   z_res = '0;
      2'b10:   z_res = WIDTH'(1);
      default: z_res = z_sel;
    endcase
    if (req_swap) begin
      x_store = z_res;
      z_store = x_sel;
    end else begin
      x_store = x_sel;
      z_store = z_res;
    end
  end

  // Handshakes and next-state logic for the pointers, occupancy and sticky error.
  always_comb begin
    req_ready = !rst && (occ_q != 2'd2);
    out_valid = (occ_q != 2'd0);
    push      = req_valid && req_ready;
    pop       = out_valid && out_ready;
    wr_ptr_d  = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d  = pop  ? ~rd_ptr_q : rd_ptr_q;
    occ_d     = occ_q;
    if (push && !pop)      occ_d = occ_q + 2'd1;
    else if (pop && !push) occ_d = occ_q - 2'd1;
    err_d = err_q;
    if (err_clr)                 err_d = 1'b0;
    if (push && (x_oor || z_oor)) err_d = 1'b1;
  end

  // When empty, the last popped entry sits behind the read pointer. Keep showing it.
  always_comb begin
    head_idx  = (occ_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
    alu_x     = x_mem_q[head_idx];
    alu_z     = z_mem_q[head_idx];
    out_tag   = tag_mem_q[head_idx];
    occupancy = occ_q;
    sel_err   = err_q;
  end

  // Control state registers. Reset discards all entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
    end
  end

  // Entry storage. It is written only on a push, and cleared on reset so the outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        x_mem_q[i]   <= '0;
        z_mem_q[i]   <= '0;
        tag_mem_q[i] <= '0;
      end
    end else if (push) begin
      x_mem_q[wr_ptr_q]   <= x_store;
      z_mem_q[wr_ptr_q]   <= z_store;
      tag_mem_q[wr_ptr_q] <= req_tag;
    end
  end

endmodule

// File: tb/tb_alu_operand_sel.sv
// Testbench for alu_operand_sel: scenario tasks and a scoreboard of expected FIFO entries.
// Inputs change 1 time unit after posedge. The scoreboard monitor samples on negedge.
// The monitor keeps its own occupancy, error and entry-queue model.
module tb_alu_operand_sel;
  localparam int W = 163, NSRC = 6, SELW = 4, TAGW = 4;

  typedef struct packed {
    logic [W-1:0]    x;
    logic [W-1:0]    z;
    logic [TAGW-1:0] tag;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NSRC*W-1:0]    src_bus;
  logic                 req_valid = 1'b0, req_ready;
  logic [SELW-1:0]      req_sel_x = '0, req_sel_z = '0;
  logic                 req_swap = 1'b0;
  logic [1:0]           req_cz = 2'b00;
  logic [TAGW-1:0]      req_tag = '0;
  logic                 out_valid, out_ready = 1'b0;
  logic [W-1:0]         alu_x, alu_z;
  logic [TAGW-1:0]      out_tag;
  logic [1:0]           occupancy;
  logic                 sel_err, err_clr = 1'b0;

  logic [W-1:0] src_v [NSRC];
  ent_t         sb_q [$];
  int           m_occ = 0;
  logic         m_err = 1'b0;
  int           n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NSRC; i++) src_bus[i*W +: W] = src_v[i];
  end

  alu_operand_sel #(.WIDTH(W), .NSRC(NSRC), .SELW(SELW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .src_bus(src_bus),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel_x(req_sel_x), .req_sel_z(req_sel_z), .req_swap(req_swap),
    .req_cz(req_cz), .req_tag(req_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_x(alu_x), .alu_z(alu_z), .out_tag(out_tag),
    .occupancy(occupancy), .sel_err(sel_err), .err_clr(err_clr)
  );

  // Reference operand computation.
  function automatic ent_t model_entry(input logic [SELW-1:0] sx, input logic [SELW-1:0] sz,
                                       input logic sw, input logic [1:0] cz, input logic [TAGW-1:0] tg);
    logic [W-1:0] xs, zs;
    ent_t e;
    xs = '0;
    zs = '0;
    if (int'(sx) < NSRC) xs = src_v[int'(sx)];
    if (int'(sz) < NSRC) zs = src_v[int'(sz)];
    if (cz == 2'b01) zs = '0;
    else if (cz == 2'b10) zs = W'(1);
    e.x   = sw ? zs : xs;
    e.z   = sw ? xs : zs;
    e.tag = tg;
    return e;
  endfunction

  // Scoreboard monitor: compares the head and flags, predicts this edge's push and pop, and updates the model.
  always @(negedge clk) begin
    logic m_push, m_pop;
    if (rst) begin
      sb_q.delete();
      m_occ = 0;
      m_err = 1'b0;
    end else begin
      n_chk++;
      if (occupancy !== 2'(m_occ) || out_valid !== (m_occ != 0) || req_ready !== (m_occ < 2)) begin
        n_fail++;
        $display("FAIL sb_flags: occ=%0d vld=%0b rdy=%0b, required occ=%0d", occupancy, out_valid, req_ready, m_occ);
      end
      n_chk++;
      if (sel_err !== m_err) begin
        n_fail++;
        $display("FAIL sb_sel_err: got %0b required %0b", sel_err, m_err);
      end
      if (m_occ != 0) begin
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: DUT holds an entry, scoreboard has none");
        end else if (alu_x !== sb_q[0].x || alu_z !== sb_q[0].z || out_tag !== sb_q[0].tag) begin
          n_fail++;
          $display("FAIL sb_head: got tag=%0d x=%0h z=%0h required tag=%0d x=%0h z=%0h",
                   out_tag, alu_x, alu_z, sb_q[0].tag, sb_q[0].x, sb_q[0].z);
        end
      end
      m_push = req_valid && (m_occ < 2);
      m_pop  = (m_occ != 0) && out_ready;
      if (m_pop && sb_q.size() != 0) void'(sb_q.pop_front());
      if (m_push) sb_q.push_back(model_entry(req_sel_x, req_sel_z, req_swap, req_cz, req_tag));
      m_occ = m_occ + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      if (m_push && (int'(req_sel_x) >= NSRC || int'(req_sel_z) >= NSRC)) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [SELW-1:0] sx, input logic [SELW-1:0] sz,
                           input logic sw, input logic [1:0] cz, input logic [TAGW-1:0] tg);
    req_valid = v;
    req_sel_x = sx;
    req_sel_z = sz;
    req_swap  = sw;
    req_cz    = cz;
    req_tag   = tg;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || req_ready !== 1'b0 || sel_err !== 1'b0 ||
        alu_x !== '0 || alu_z !== '0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_state: occ=%0d vld=%0b rdy=%0b err=%0b x=%0h z=%0h tag=%0d",
               occupancy, out_valid, req_ready, sel_err, alu_x, alu_z, out_tag);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: got %0b required 1", req_ready);
    end
  endtask

  task automatic test_basic();
    tick();
    out_ready = 1'b1;
    drive_req(1'b1, 4'd3, 4'd0, 1'b0, 2'b00, 4'd5);
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0);
    n_chk++;
    if (out_valid !== 1'b1 || alu_x !== W'(12'hABC) || alu_z !== W'(1) || out_tag !== 4'd5) begin
      n_fail++;
      $display("FAIL basic_select: vld=%0b x=%0h z=%0h tag=%0d required 1 abc 1 5", out_valid, alu_x, alu_z, out_tag);
    end
    tick();
    n_chk++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || alu_x !== W'(12'hABC)) begin
      n_fail++;
      $display("FAIL basic_drain_hold: occ=%0d vld=%0b x=%0h required 0 0 abc", occupancy, out_valid, alu_x);
    end
  endtask

  task automatic test_swap_const();
    drive_req(1'b1, 4'd2, 4'd4, 1'b1, 2'b10, 4'd6);
    tick();
    drive_req(1'b1, 4'd2, 4'd4, 1'b0, 2'b01, 4'd7);
    n_chk++;
    if (alu_x !== W'(1) || alu_z !== W'(8'h77) || out_tag !== 4'd6) begin
      n_fail++;
      $display("FAIL swap_one: x=%0h z=%0h tag=%0d required 1 77 6", alu_x, alu_z, out_tag);
    end
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0);
    n_chk++;
    if (alu_x !== W'(8'h77) || alu_z !== '0 || out_tag !== 4'd7) begin
      n_fail++;
      $display("FAIL force_zero: x=%0h z=%0h tag=%0d required 77 0 7", alu_x, alu_z, out_tag);
    end
    tick();
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    drive_req(1'b1, 4'd1, 4'd2, 1'b0, 2'b00, 4'd1);
    tick();
    drive_req(1'b1, 4'd4, 4'd5, 1'b0, 2'b00, 4'd2);
    tick();
    drive_req(1'b1, 4'd5, 4'd3, 1'b1, 2'b00, 4'd3);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (occupancy !== 2'd2 || req_ready !== 1'b0 || out_tag !== 4'd1) begin
        n_fail++;
        $display("FAIL full_hold: occ=%0d rdy=%0b tag=%0d required 2 0 1", occupancy, req_ready, out_tag);
      end
      if (k == 1) out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    n_chk++;
    if (out_tag !== 4'd2 || req_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL full_pop_reopen: tag=%0d rdy=%0b occ=%0d required 2 1 1", out_tag, req_ready, occupancy);
    end
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0);
    out_ready = 1'b1;
    n_chk++;
    if (occupancy !== 2'd2 || out_tag !== 4'd2) begin
      n_fail++;
      $display("FAIL full_third_accept: occ=%0d tag=%0d required 2 2", occupancy, out_tag);
    end
    tick();
    n_chk++;
    if (out_tag !== 4'd3) begin
      n_fail++;
      $display("FAIL full_order: tag=%0d required 3", out_tag);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_req(1'b1, 4'd0, 4'd1, 1'b0, 2'b00, 4'd8);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b1, 4'(k), 4'(5 - k), k[0], 2'(k), 4'(9 + k));
      n_chk++;
      if (occupancy !== 2'd1 || out_tag !== 4'(8 + k)) begin
        n_fail++;
        $display("FAIL b2b_step%0d: occ=%0d tag=%0d required 1 %0d", k, occupancy, out_tag, 8 + k);
      end
      tick();
    end
    drive_req(1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0);
    n_chk++;
    if (occupancy !== 2'd1 || out_tag !== 4'd12) begin
      n_fail++;
      $display("FAIL b2b_last: occ=%0d tag=%0d required 1 12", occupancy, out_tag);
    end
    tick();
  endtask

  task automatic test_err();
    out_ready = 1'b1;
    drive_req(1'b1, 4'd3, 4'd7, 1'b0, 2'b00, 4'd9);
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0);
    n_chk++;
    if (sel_err !== 1'b1 || alu_z !== '0 || alu_x !== W'(12'hABC)) begin
      n_fail++;
      $display("FAIL err_set: err=%0b z=%0h x=%0h required 1 0 abc", sel_err, alu_z, alu_x);
    end
    tick();
    tick();
    n_chk++;
    if (sel_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %0b required 1", sel_err);
    end
    drive_req(1'b1, 4'd9, 4'd1, 1'b0, 2'b00, 4'd10);
    err_clr = 1'b1;
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0);
    err_clr = 1'b0;
    n_chk++;
    if (sel_err !== 1'b1 || alu_x !== '0) begin
      n_fail++;
      $display("FAIL err_set_wins: err=%0b x=%0h required 1 0", sel_err, alu_x);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++;
    if (sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %0b required 0", sel_err);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_req(1'b1, 4'd1, 4'd2, 1'b0, 2'b00, 4'd1);
    tick();
    drive_req(1'b1, 4'd2, 4'd1, 1'b0, 2'b00, 4'd2);
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 4'd0);
    n_chk++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL rstmid_fill: occ=%0d required 2", occupancy);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || req_ready !== 1'b0 ||
        alu_x !== '0 || alu_z !== '0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: vld=%0b occ=%0d rdy=%0b x=%0h z=%0h tag=%0d required all 0",
               out_valid, occupancy, req_ready, alu_x, alu_z, out_tag);
    end
    tick();
    rst = 1'b0;
    #1;
    out_ready = 1'b1;
    n_chk++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: rdy=%0b vld=%0b required 1 0", req_ready, out_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale: out_valid=%0b required 0", out_valid);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NSRC; i++) src_v[i] = W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    src_v[0] = W'(1);
    src_v[2] = W'(8'h77);
    src_v[3] = W'(12'hABC);
    test_reset();
    test_basic();
    test_swap_const();
    test_full();
    test_back_to_back();
    test_err();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
